// File: rtl/cla_pkg.sv
// Shared types and helpers for the serial carry-lookahead adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cla_pkg;

    // Width of one lookahead slice processed per cycle.
    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement overflow of the full-width add. The MSB sum bit is
    // a^b^c_in_msb, so a^b^s recovers the carry into the MSB; overflow is
    // that carry differing from the carry out of the MSB.
    function automatic logic signed_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb,
        input logic c_out
    );
        return (a_msb ^ b_msb ^ s_msb) ^ c_out;
    endfunction

endpackage

// File: rtl/cla4_core.sv
// Purely combinational 4-bit carry-lookahead adder slice.
// Latency: 0 cycles (combinational).
// Backpressure: none; ports a,b,ci -> s,co.
module cla4_core (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;
    logic       c3;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p/ci: no carry depends on
    // another computed carry, so the slice has a constant two-level depth.
    assign c1 = g[0]
              | (p[0] & ci);
    assign c2 = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & ci);
    assign c3 = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign co = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/serial_cla_adder.sv
// WIDTH-bit adder that processes one 4-bit CLA slice per cycle; ports: clk, rst_n,
//   in_valid/in_ready + a,b,cin in; out_valid/out_ready + sum,cout,ovf out.
// Latency: out_valid rises NIB edges after the accept edge; one op in flight, II = NIB+2.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no drain/accept overlap.
module serial_cla_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = $clog2(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t state;
    state_t state_nxt;

    // a_sh doubles as the partial-sum register: each RUN edge consumes the
    // low nibble of A and the freshly computed sum nibble fills the vacated
    // top nibble, so after NIB edges {s, a_sh[WIDTH-1:4]} is the full sum.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             a_msb;
    logic             b_msb;
    logic             carry;
    logic [IDX_W-1:0] idx;

    logic [3:0]       s;
    logic             c4;
    logic             accept;
    logic             last;

    cla4_core u_core (
        .a  (a_sh[NIBBLE_W-1:0]),
        .b  (b_sh[NIBBLE_W-1:0]),
        .ci (carry),
        .s  (s),
        .co (c4)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign last      = (state == RUN) && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
                carry <= cin;
                idx   <= '0;
            end else if (state == RUN) begin
                a_sh  <= {s, a_sh[WIDTH-1:NIBBLE_W]};
                b_sh  <= {{NIBBLE_W{1'b0}}, b_sh[WIDTH-1:NIBBLE_W]};
                carry <= c4;
                idx   <= idx + IDX_W'(1);
                // Outputs only change here, so the previous result stays
                // visible while the next operation is in progress.
                if (last) begin
                    sum  <= {s, a_sh[WIDTH-1:NIBBLE_W]};
                    cout <= c4;
                    ovf  <= signed_ovf(a_msb, b_msb, s[3], c4);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_cla_adder.sv
module tb_serial_cla_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp  = 0;
    int n_fail = 0;
    int acc_cnt = 0;
    int drn_cnt = 0;

    serial_cla_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake counters, sampled mid-cycle where inputs and state are stable.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) acc_cnt++;
            if (out_valid && out_ready) drn_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running required finished");
        $fatal(1, "watchdog");
    end

    // Offer an operand pair and return just after the accept edge; operand
    // inputs are scrambled afterwards since they must only be sampled at accept.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv,
                            input logic cv, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (ok) begin
            in_valid = 1'b1;
            a = av;
            b = bv;
            cin = cv;
            @(posedge clk); #1;
            in_valid = 1'b0;
            a = ~av;
            b = 16'hA5A5;
            cin = ~cv;
        end
    endtask

    // Count edges after accept until out_valid is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        n_cmp++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h required 0000", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b required 0", cout); end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [15:0] va [5] = '{16'h00FF, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] vb [5] = '{16'h0001, 16'h0001, 16'h0000, 16'h0001, 16'h8000};
        logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] es [5] = '{16'h0100, 16'h0000, 16'h0000, 16'h8000, 16'h0000};
        logic        ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] prev_sum;
        bit ok;
        int lat;
        prev_sum = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i], vc[i], ok);
            n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL vec%0d_accept: got %b required 1", i, ok); end
            n_cmp++; if (sum !== prev_sum) begin n_fail++; $display("FAIL vec%0d_hold_in_run: got %h required %h", i, sum, prev_sum); end
            wait_done(lat);
            n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL vec%0d_latency: got %0d required 4", i, lat); end
            n_cmp++; if (sum !== es[i]) begin n_fail++; $display("FAIL vec%0d_sum: got %h required %h", i, sum, es[i]); end
            n_cmp++; if (cout !== ec[i]) begin n_fail++; $display("FAIL vec%0d_cout: got %b required %b", i, cout, ec[i]); end
            n_cmp++; if (ovf !== eo[i]) begin n_fail++; $display("FAIL vec%0d_ovf: got %b required %b", i, ovf, eo[i]); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL vec%0d_in_ready_done: got %b required 0", i, in_ready); end
            drain();
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL vec%0d_in_ready_after: got %b required 1", i, in_ready); end
            prev_sum = es[i];
        end
    endtask

    task automatic test_out_ready_early();
        bit ok;
        int lat;
        start_op(16'h0F0F, 16'h00F1, 1'b0, ok);
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL early_ready_valid: got %b required 0", out_valid); end
        wait_done(lat);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL early_ready_latency: got %0d more edges required 2", lat); end
        n_cmp++; if (sum !== 16'h1000) begin n_fail++; $display("FAIL early_ready_sum: got %h required 1000", sum); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL early_ready_drain: got %b required 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int lat;
        start_op(16'h1111, 16'h2222, 1'b1, ok);
        wait_done(lat);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL bp_latency: got %0d required 4", lat); end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 16'hDEAD;
            b = 16'hBEEF;
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_%0d: got %b required 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_%0d: got %b required 0", i, in_ready); end
            n_cmp++; if (sum !== 16'h3334) begin n_fail++; $display("FAIL bp_sum_%0d: got %h required 3334", i, sum); end
            n_cmp++; if (cout !== 1'b0) begin n_fail++; $display("FAIL bp_cout_%0d: got %b required 0", i, cout); end
        end
        in_valid = 1'b0;
        drain();
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release: got %b required 1", in_ready); end
        start_op(16'hABCD, 16'h1234, 1'b0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b required 1", ok); end
        wait_done(lat);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL b2b_latency: got %0d required 4", lat); end
        n_cmp++; if (sum !== 16'hBE01) begin n_fail++; $display("FAIL b2b_sum: got %h required be01", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_fail++; $display("FAIL b2b_cout: got %b required 0", cout); end
        n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b required 0", ovf); end
        drain();
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int lat;
        start_op(16'h0F0F, 16'h0101, 1'b0, ok);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b required 0", out_valid); end
        n_cmp++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL midrst_sum: got %h required 0000", sum); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b required 1", in_ready); end
        rst_n = 1'b1;
        start_op(16'h1234, 16'h4321, 1'b0, ok);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_first_accept: got in_ready %b required 0", in_ready); end
        wait_done(lat);
        n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL midrst_latency: got %0d required 4", lat); end
        n_cmp++; if (sum !== 16'h5555) begin n_fail++; $display("FAIL midrst_sum_after: got %h required 5555", sum); end
        n_cmp++; if (cout !== 1'b0) begin n_fail++; $display("FAIL midrst_cout_after: got %b required 0", cout); end
        drain();
    endtask

    task automatic test_sweep();
        bit ok;
        int lat;
        int acc0;
        int drn0;
        logic [15:0] av;
        logic [15:0] bv;
        logic [16:0] e;
        acc0 = acc_cnt;
        drn0 = drn_cnt;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    av = {12'hFFF, 4'(x)};
                    bv = {12'hFFF, 4'(y)};
                    e  = {1'b0, av} + {1'b0, bv} + {16'b0, 1'(c)};
                    start_op(av, bv, 1'(c), ok);
                    wait_done(lat);
                    n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL sweep_latency %h+%h+%0d: got %0d required 4", av, bv, c, lat); end
                    n_cmp++; if (sum !== e[15:0]) begin n_fail++; $display("FAIL sweep_sum %h+%h+%0d: got %h required %h", av, bv, c, sum, e[15:0]); end
                    n_cmp++; if (cout !== e[16]) begin n_fail++; $display("FAIL sweep_cout %h+%h+%0d: got %b required %b", av, bv, c, cout, e[16]); end
                    // Both operands negative: overflow iff the sum turned non-negative.
                    n_cmp++; if (ovf !== ~e[15]) begin n_fail++; $display("FAIL sweep_ovf %h+%h+%0d: got %b required %b", av, bv, c, ovf, ~e[15]); end
                    drain();
                end
            end
        end
        n_cmp++; if (acc_cnt - acc0 !== 512) begin n_fail++; $display("FAIL sweep_accepts: got %0d required 512", acc_cnt - acc0); end
        n_cmp++; if (drn_cnt - drn0 !== 512) begin n_fail++; $display("FAIL sweep_drains: got %0d required 512", drn_cnt - drn0); end
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;
        cin       = 1'b0;
        test_reset();
        test_vectors();
        test_out_ready_early();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
